// File: rtl/axi_slv_pkg.sv
// Shared constants and FSM state types for the AXI4-full RAM slave.
package axi_slv_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

endpackage

// File: rtl/axi_slv_dpram.sv
// 1W1R synchronous RAM with byte write enables and an enabled, registered read port.
// A same-address read and write in one cycle returns the old word.
module axi_slv_dpram #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_waddr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic                i_re,
  input  logic [ADDR_W-1:0]   i_raddr,
  output logic [DATA_W-1:0]   o_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Array is deliberately not reset so contents survive a bus reset.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (i_we && i_wstrb[b]) begin
        r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_full_slave_ram.sv
// AXI4-full slave backed by on-chip RAM; independent write and read FSMs, one burst each.
// Define AXI_SLV_OOR_ERR_EN to answer out-of-range beats with SLVERR instead of wrapping.
module axi_full_slave_ram
  import axi_slv_pkg::*;
#(
  parameter int unsigned                    C_S_AXI_ID_WIDTH   = 1,
  parameter int unsigned                    C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned                    C_S_AXI_DATA_WIDTH = 128,
  parameter int unsigned                    C_MEM_DEPTH        = 1024,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0]  C_S_AXI_BASE_ADDR  = 32'h4000_0000
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [7:0]                        S_AXI_AWLEN,
  input  logic [2:0]                        S_AXI_AWSIZE,
  input  logic [1:0]                        S_AXI_AWBURST,
  input  logic                              S_AXI_AWLOCK,
  input  logic [3:0]                        S_AXI_AWCACHE,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic [3:0]                        S_AXI_AWQOS,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WLAST,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_BID,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [7:0]                        S_AXI_ARLEN,
  input  logic [2:0]                        S_AXI_ARSIZE,
  input  logic [1:0]                        S_AXI_ARBURST,
  input  logic                              S_AXI_ARLOCK,
  input  logic [3:0]                        S_AXI_ARCACHE,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic [3:0]                        S_AXI_ARQOS,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RLAST,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY
);

  localparam int unsigned ADDR_W  = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned ID_W    = C_S_AXI_ID_WIDTH;
  localparam int unsigned DATA_W  = C_S_AXI_DATA_WIDTH;
  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned SZ_LOG  = $clog2(STRB_W);
  localparam int unsigned IDX_W   = $clog2(C_MEM_DEPTH);
  localparam logic [2:0]  LP_SIZE = 3'(SZ_LOG);
`ifdef AXI_SLV_OOR_ERR_EN
  // Keep the full word offset so out-of-range beats can be detected.
  localparam int unsigned OFF_W   = ADDR_W - SZ_LOG;
`else
  localparam int unsigned OFF_W   = IDX_W;
`endif

  // Address decode
  logic [ADDR_W-1:0] w_aw_byte, w_ar_byte;
  logic [OFF_W-1:0]  w_aw_off, w_ar_off;
  logic              w_aw_under, w_ar_under;

  assign w_aw_byte = S_AXI_AWADDR - C_S_AXI_BASE_ADDR;
  assign w_ar_byte = S_AXI_ARADDR - C_S_AXI_BASE_ADDR;
  assign w_aw_off  = w_aw_byte[SZ_LOG +: OFF_W];
  assign w_ar_off  = w_ar_byte[SZ_LOG +: OFF_W];

  // Write channel state
  w_state_e          r_wstate, w_wstate_nxt;
  logic              r_awready, w_awready_nxt;
  logic              r_wready, w_wready_nxt;
  logic              r_bvalid, w_bvalid_nxt;
  logic [1:0]        r_bresp, w_bresp_nxt;
  logic [ID_W-1:0]   r_bid, w_bid_nxt;
  logic [OFF_W-1:0]  r_woff, w_woff_nxt;
  logic              r_wunder, w_wunder_nxt;
  logic [7:0]        r_wlen, w_wlen_nxt;
  logic              r_wfixed, w_wfixed_nxt;
  logic              r_werr, w_werr_nxt;
  logic [8:0]        r_wcnt, w_wcnt_nxt;
  logic              w_wbeat_oor, w_werr_beat;
  logic              w_ram_we;

  // Read channel state
  r_state_e          r_rstate, w_rstate_nxt;
  logic              r_arready, w_arready_nxt;
  logic              r_rvalid, w_rvalid_nxt;
  logic              r_rlast, w_rlast_nxt;
  logic [1:0]        r_rresp, w_rresp_nxt;
  logic [ID_W-1:0]   r_rid, w_rid_nxt;
  logic [OFF_W-1:0]  r_roff, w_roff_nxt;
  logic              r_runder, w_runder_nxt;
  logic [7:0]        r_rlen, w_rlen_nxt;
  logic              r_rfixed, w_rfixed_nxt;
  logic              r_rerr, w_rerr_nxt;
  logic [8:0]        r_rcnt, w_rcnt_nxt;
  logic              r_rzero, w_rzero_nxt;
  logic              w_rbeat_oor;
  logic              w_ram_re;
  logic [DATA_W-1:0] w_ram_rdata;
  logic              w_unused;

`ifdef AXI_SLV_OOR_ERR_EN
  assign w_aw_under  = S_AXI_AWADDR < C_S_AXI_BASE_ADDR;
  assign w_ar_under  = S_AXI_ARADDR < C_S_AXI_BASE_ADDR;
  assign w_wbeat_oor = r_wunder || (r_woff >= OFF_W'(C_MEM_DEPTH));
  assign w_rbeat_oor = r_runder || (r_roff >= OFF_W'(C_MEM_DEPTH));
  assign w_unused    = ^{S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS,
                         S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS,
                         w_aw_byte[SZ_LOG-1:0], w_ar_byte[SZ_LOG-1:0]};
`else
  assign w_aw_under  = 1'b0;
  assign w_ar_under  = 1'b0;
  assign w_wbeat_oor = 1'b0;
  assign w_rbeat_oor = 1'b0;
  assign w_unused    = ^{S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS,
                         S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS,
                         w_aw_byte[SZ_LOG-1:0], w_ar_byte[SZ_LOG-1:0],
                         w_aw_byte[ADDR_W-1:SZ_LOG+IDX_W], w_ar_byte[ADDR_W-1:SZ_LOG+IDX_W],
                         r_wunder, r_runder};
`endif

  always_comb begin
    w_wstate_nxt  = r_wstate;
    w_awready_nxt = r_awready;
    w_wready_nxt  = r_wready;
    w_bvalid_nxt  = r_bvalid;
    w_bresp_nxt   = r_bresp;
    w_bid_nxt     = r_bid;
    w_woff_nxt    = r_woff;
    w_wunder_nxt  = r_wunder;
    w_wlen_nxt    = r_wlen;
    w_wfixed_nxt  = r_wfixed;
    w_werr_nxt    = r_werr;
    w_wcnt_nxt    = r_wcnt;
    w_werr_beat   = r_werr;
    w_ram_we      = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        w_awready_nxt = 1'b1;
        if (S_AXI_AWVALID && r_awready) begin
          w_wstate_nxt  = W_DATA;
          w_awready_nxt = 1'b0;
          w_wready_nxt  = 1'b1;
          w_bid_nxt     = S_AXI_AWID;
          w_woff_nxt    = w_aw_off;
          w_wunder_nxt  = w_aw_under;
          w_wlen_nxt    = S_AXI_AWLEN;
          w_wfixed_nxt  = S_AXI_AWBURST == BURST_FIXED;
          w_werr_nxt    = (S_AXI_AWSIZE != LP_SIZE) || (S_AXI_AWBURST == BURST_WRAP);
          w_wcnt_nxt    = '0;
        end
      end
      W_DATA: begin
        if (S_AXI_WVALID && r_wready) begin
          // Beats past LEN+1 are swallowed without touching the RAM.
          if (r_wcnt <= {1'b0, r_wlen}) begin
            w_ram_we    = !w_wbeat_oor;
            w_werr_beat = r_werr || w_wbeat_oor;
          end
          w_werr_nxt = w_werr_beat;
          if (!r_wfixed) w_woff_nxt = r_woff + OFF_W'(1);
          if (r_wcnt != '1) w_wcnt_nxt = r_wcnt + 9'd1;
          if (S_AXI_WLAST) begin
            w_wstate_nxt = W_RESP;
            w_wready_nxt = 1'b0;
            w_bvalid_nxt = 1'b1;
            w_bresp_nxt  = (w_werr_beat || (r_wcnt != {1'b0, r_wlen})) ? RESP_SLVERR
                                                                        : RESP_OKAY;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          w_bvalid_nxt  = 1'b0;
          w_wstate_nxt  = W_IDLE;
          w_awready_nxt = 1'b1;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_bid     <= '0;
      r_woff    <= '0;
      r_wunder  <= 1'b0;
      r_wlen    <= '0;
      r_wfixed  <= 1'b0;
      r_werr    <= 1'b0;
      r_wcnt    <= '0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bresp   <= w_bresp_nxt;
      r_bid     <= w_bid_nxt;
      r_woff    <= w_woff_nxt;
      r_wunder  <= w_wunder_nxt;
      r_wlen    <= w_wlen_nxt;
      r_wfixed  <= w_wfixed_nxt;
      r_werr    <= w_werr_nxt;
      r_wcnt    <= w_wcnt_nxt;
    end
  end

  // A new word is fetched only when the output slot is empty or being drained.
  assign w_ram_re = (r_rstate == R_DATA) && (r_rcnt <= {1'b0, r_rlen}) &&
                    (!r_rvalid || S_AXI_RREADY);

  always_comb begin
    w_rstate_nxt  = r_rstate;
    w_arready_nxt = r_arready;
    w_rvalid_nxt  = r_rvalid;
    w_rlast_nxt   = r_rlast;
    w_rresp_nxt   = r_rresp;
    w_rid_nxt     = r_rid;
    w_roff_nxt    = r_roff;
    w_runder_nxt  = r_runder;
    w_rlen_nxt    = r_rlen;
    w_rfixed_nxt  = r_rfixed;
    w_rerr_nxt    = r_rerr;
    w_rcnt_nxt    = r_rcnt;
    w_rzero_nxt   = r_rzero;
    unique case (r_rstate)
      R_IDLE: begin
        w_arready_nxt = 1'b1;
        if (S_AXI_ARVALID && r_arready) begin
          w_rstate_nxt  = R_DATA;
          w_arready_nxt = 1'b0;
          w_rid_nxt     = S_AXI_ARID;
          w_roff_nxt    = w_ar_off;
          w_runder_nxt  = w_ar_under;
          w_rlen_nxt    = S_AXI_ARLEN;
          w_rfixed_nxt  = S_AXI_ARBURST == BURST_FIXED;
          w_rerr_nxt    = (S_AXI_ARSIZE != LP_SIZE) || (S_AXI_ARBURST == BURST_WRAP);
          w_rcnt_nxt    = '0;
        end
      end
      R_DATA: begin
        if (r_rvalid && S_AXI_RREADY) begin
          w_rvalid_nxt = 1'b0;
          if (r_rlast) begin
            w_rlast_nxt   = 1'b0;
            w_rstate_nxt  = R_IDLE;
            w_arready_nxt = 1'b1;
          end
        end
        if (w_ram_re) begin
          w_rvalid_nxt = 1'b1;
          w_rlast_nxt  = r_rcnt == {1'b0, r_rlen};
          w_rresp_nxt  = (r_rerr || w_rbeat_oor) ? RESP_SLVERR : RESP_OKAY;
          w_rzero_nxt  = w_rbeat_oor;
          if (!r_rfixed) w_roff_nxt = r_roff + OFF_W'(1);
          w_rcnt_nxt   = r_rcnt + 9'd1;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rid     <= '0;
      r_roff    <= '0;
      r_runder  <= 1'b0;
      r_rlen    <= '0;
      r_rfixed  <= 1'b0;
      r_rerr    <= 1'b0;
      r_rcnt    <= '0;
      r_rzero   <= 1'b0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rlast   <= w_rlast_nxt;
      r_rresp   <= w_rresp_nxt;
      r_rid     <= w_rid_nxt;
      r_roff    <= w_roff_nxt;
      r_runder  <= w_runder_nxt;
      r_rlen    <= w_rlen_nxt;
      r_rfixed  <= w_rfixed_nxt;
      r_rerr    <= w_rerr_nxt;
      r_rcnt    <= w_rcnt_nxt;
      r_rzero   <= w_rzero_nxt;
    end
  end

  axi_slv_dpram #(
    .DEPTH  (C_MEM_DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .i_clk   (S_AXI_ACLK),
    .i_rst_n (S_AXI_ARESETN),
    .i_we    (w_ram_we),
    .i_waddr (r_woff[IDX_W-1:0]),
    .i_wdata (S_AXI_WDATA),
    .i_wstrb (S_AXI_WSTRB),
    .i_re    (w_ram_re),
    .i_raddr (r_roff[IDX_W-1:0]),
    .o_rdata (w_ram_rdata)
  );

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_BID     = r_bid;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RLAST   = r_rlast;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RID     = r_rid;
  assign S_AXI_RDATA   = r_rzero ? '0 : w_ram_rdata;

endmodule
